muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide unit with its own sequencing FSM, placed in the EX stage beside the ALU.
//  Accepts an M-extension op decoded by the controller (funct3 passed through as funct3E).
//  Holds stallE high while iterating so the hazard logic freezes F/D/E. Presents a one-cycle result at DONE.
// PARAMETERS
//  XLEN  32  operand/result width; iteration counter width is $clog2(XLEN)+1
// PORTS
//  clk      in   1     clock, all state on rising edge
//  rst_n    in   1     synchronous reset, active low
//  startE   in   1     valid M-op present in EX (op=0110011, funct7=0000001)
//  funct3E  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  srcAE    in   XLEN  rs1 operand (forwarded)
//  srcBE    in   XLEN  rs2 operand (forwarded)
//  flushE   in   1     EX flush (branch/jump redirect); aborts any op
//  stallE   out  1     freeze pipeline up to EX
//  doneE    out  1     resultE valid this cycle
//  resultE  out  XLEN  M-op result
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, counter=0, internal regs=0. Applies mid-operation: op discarded, no doneE.
//  Outputs: stallE=0, doneE=0, resultE=0 while in reset and in IDLE.
//  FSM states IDLE, MUL, DIV, DONE:
//   IDLE: startE&!flushE -> latch funct3, |A|,|B| and result-sign flags; MUL if funct3[2]=0, else DIV.
//     DIV with srcBE=0 or signed overflow -> DONE directly.
//   MUL/DIV: one shift-add / restoring-subtract step per cycle for XLEN cycles -> DONE.
//   DONE: doneE=1, stallE=0, resultE driven -> IDLE. startE ignored in DONE (same instruction leaving EX).
//   flushE in any state -> IDLE next edge, no doneE; flush wins over startE.
//  stallE combinational: (state==IDLE & startE & !flushE) | state==MUL | state==DIV.
//  Latency: accept at cycle 0, doneE at cycle XLEN+1 (stallE high cycles 0..XLEN).
//   Special-case divide: doneE at cycle 1.
//  Multiply: 2*XLEN product of magnitudes, then negate if sign flag set.
//   MUL returns low half; MULH/MULHSU/MULHU return high half.
//   Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU neither.
//  Divide: magnitudes for DIV/REM.
//   Quotient sign = sA^sB; remainder sign = sA. Negation applied in DONE path.
//  Div by zero: DIV/DIVU -> all ones; REM/REMU -> srcAE.
//  Overflow (DIV/REM, A=1<<(XLEN-1), B=-1): DIV -> A; REM -> 0.
//  Operands latched at accept; later changes of srcAE/srcBE have no effect.
//  Counter never wraps: saturates transition to DONE at XLEN.
// TESTING
//  MUL 7 x 0xFFFFFFFD -> resultE=0xFFFFFFEB; stallE high 33 cycles, doneE at cycle 33.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; doneE at cycle 1.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
//  Abort cases:
//   flushE at cycle 10 of DIV -> IDLE, stallE=0, no doneE; next start completes normally.
//   rst_n=0 mid-MUL -> same.
//   startE held through DONE -> exactly one doneE.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
// Latency: XLEN+1 cycles from accept to doneE; divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: holds stallE while accepting/iterating; flushE or reset aborts with no doneE.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            startE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] srcAE,
   input  logic [XLEN-1:0] srcBE,
   input  logic            flushE,
   output logic            stallE,
   output logic            doneE,
   output logic [XLEN-1:0] resultE
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [2:0]      f3;
   logic            neg;
   logic [XLEN-1:0] opb;   // multiplicand or divisor magnitude
   logic [XLEN-1:0] hi;    // product high half / partial remainder
   logic [XLEN-1:0] lo;    // product low half (multiplier) / quotient (dividend)

   logic            a_sgn, b_sgn, sa, sb;
   logic [XLEN-1:0] mag_a, mag_b, sp_res;
   logic            div_zero, div_ovf;
   logic [XLEN:0]   mul_sum, div_sh, div_diff;
   logic            div_ge, last;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0] mul_out, div_val, div_out, res;

   // Operand decode at accept: signedness per op, magnitudes and the one-cycle divide cases
   always_comb begin
      a_sgn    = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] == 2'b01 || funct3E[1:0] == 2'b10);
      b_sgn    = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] == 2'b01);
      sa       = a_sgn & srcAE[XLEN-1];
      sb       = b_sgn & srcBE[XLEN-1];
      mag_a    = sa ? -srcAE : srcAE;
      mag_b    = sb ? -srcBE : srcBE;
      div_zero = (srcBE == '0);
      div_ovf  = ~funct3E[0] && (srcAE == {1'b1, {(XLEN-1){1'b0}}}) && (&srcBE);
      if (div_zero)
         sp_res = funct3E[1] ? srcAE : '1;
      else
         sp_res = funct3E[1] ? '0 : srcAE;
   end

   // One shift-add step and one restoring-subtract step, sharing the hi/lo pair
   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
      div_sh   = {hi, lo[XLEN-1]};
      div_diff = div_sh - {1'b0, opb};
      div_ge   = ~div_diff[XLEN];
      last     = (cnt == CW'(XLEN-1));
   end

   // Result formation: sign fix-up on the magnitude result, then half/quotient/remainder select
   always_comb begin
      prod    = {hi, lo};
      prod_s  = neg ? -prod : prod;
      mul_out = (f3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      div_val = f3[1] ? hi : lo;
      div_out = neg ? -div_val : div_val;
      res     = f3[2] ? div_out : mul_out;
   end

   // Outputs are quiet in reset and outside DONE; stall covers the accept cycle too
   always_comb begin
      stallE  = rst_n && ((state == S_IDLE && startE && !flushE) ||
                          state == S_MUL || state == S_DIV);
      doneE   = rst_n && (state == S_DONE) && !flushE;
      resultE = (rst_n && state == S_DONE) ? res : '0;
   end

   // Sequencer: accept, iterate XLEN steps, present result for one cycle; flush aborts anywhere
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         f3    <= '0;
         neg   <= 1'b0;
         opb   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (flushE) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (startE) begin
                  f3  <= funct3E;
                  cnt <= '0;
                  opb <= mag_b;
                  if (funct3E[2] && (div_zero || div_ovf)) begin
                     hi    <= sp_res;
                     lo    <= sp_res;
                     neg   <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     hi    <= '0;
                     lo    <= mag_a;
                     neg   <= (funct3E[2] && funct3E[1]) ? sa : (sa ^ sb);
                     state <= funct3E[2] ? S_DIV : S_MUL;
                  end
               end
            end
            S_MUL: begin
               hi  <= mul_sum[XLEN:1];
               lo  <= {mul_sum[0], lo[XLEN-1:1]};
               cnt <= cnt + 1'b1;
               if (last) state <= S_DONE;
            end
            S_DIV: begin
               hi  <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
               lo  <= {lo[XLEN-2:0], div_ge};
               cnt <= cnt + 1'b1;
               if (last) state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus abort/hold sequences.
// Inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Cycle 0 is the accept cycle; latency is the cycle index at which doneE is seen.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        startE;
   logic [2:0]  funct3E;
   logic [31:0] srcAE;
   logic [31:0] srcBE;
   logic        flushE;
   logic        stallE;
   logic        doneE;
   logic [31:0] resultE;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   muldiv_seq #(.XLEN(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .startE  (startE),
      .funct3E (funct3E),
      .srcAE   (srcAE),
      .srcBE   (srcBE),
      .flushE  (flushE),
      .stallE  (stallE),
      .doneE   (doneE),
      .resultE (resultE)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Launch one op from IDLE, scramble operands after accept, check result, latency and stall count
   task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int  cyc    = 0;
      int  stalls = 0;
      bit  got    = 0;
      startE  = 1'b1;
      funct3E = f;
      srcAE   = a;
      srcBE   = b;
      while (!got && cyc < 100) begin
         @(negedge clk);
         if (stallE) stalls++;
         if (doneE) begin
            got = 1;
            check({nm, " result"}, resultE, exp);
            check({nm, " latency"}, 32'(cyc), 32'(lat));
            check({nm, " stall_cycles"}, 32'(stalls), 32'(lat));
         end
         @(posedge clk); #1;
         startE  = 1'b0;
         funct3E = 3'($urandom);
         srcAE   = $urandom;
         srcBE   = $urandom;
         cyc++;
      end
      if (!got) check({nm, " timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      check({nm, " idle_after_done"}, {30'd0, stallE, doneE}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      vecs.push_back('{"mul_7_neg3",    3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
      vecs.push_back('{"mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33});
      vecs.push_back('{"mulhu_max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
      vecs.push_back('{"div_by_zero",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
      vecs.push_back('{"rem_by_zero",   3'b110, 32'd5,        32'd0,        32'd5,        1});
      vecs.push_back('{"divu_by_zero",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
      vecs.push_back('{"remu_by_zero",  3'b111, 32'd5,        32'd0,        32'd5,        1});
      vecs.push_back('{"div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
      vecs.push_back('{"rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
      vecs.push_back('{"rem_neg7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
      vecs.push_back('{"divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       33});
      vecs.push_back('{"remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        33});
      vecs.push_back('{"div_neg7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
      vecs.push_back('{"mulhsu_neg1_2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
      vecs.push_back('{"mulh_neg1_3",   3'b001, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF, 33});
      vecs.push_back('{"mulhu_max_3",   3'b011, 32'hFFFFFFFF, 32'd3,        32'd2,        33});
      vecs.push_back('{"mul_small",     3'b000, 32'h12345,    32'h100,      32'h01234500, 33});
      vecs.push_back('{"div_min_1",     3'b100, 32'h80000000, 32'd1,        32'h80000000, 33});

      rst_n   = 1'b0;
      startE  = 1'b1;
      funct3E = 3'b000;
      srcAE   = 32'd3;
      srcBE   = 32'd4;
      flushE  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {stallE, doneE, resultE[29:0]}, 32'd0);
      check("reset_result", resultE, 32'd0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      startE = 1'b0;
      @(negedge clk);
      check("idle_outputs", {30'd0, stallE, doneE}, 32'd0);
      check("idle_result", resultE, 32'd0);
      @(posedge clk); #1;

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      // flush wins over start in IDLE
      begin
         startE = 1'b1; flushE = 1'b1; funct3E = 3'b000; srcAE = 32'd2; srcBE = 32'd3;
         @(negedge clk);
         check("flush_vs_start_stall", {31'd0, stallE}, 32'd0);
         @(posedge clk); #1;
         startE = 1'b0; flushE = 1'b0;
         @(negedge clk);
         check("flush_vs_start_noop", {31'd0, stallE}, 32'd0);
         @(posedge clk); #1;
      end

      // flush at cycle 10 of a divide
      begin
         int dones = 0;
         startE = 1'b1; funct3E = 3'b101; srcAE = 32'd100; srcBE = 32'd7;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (doneE) dones++;
            @(posedge clk); #1;
            startE = 1'b0;
         end
         flushE = 1'b1;
         @(posedge clk); #1;
         flushE = 1'b0;
         @(negedge clk);
         check("flush_div_stall", {31'd0, stallE}, 32'd0);
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (doneE) dones++;
         end
         check("flush_div_no_done", 32'(dones), 32'd0);
         @(posedge clk); #1;
         run_op("after_flush_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
      end

      // reset mid-multiply
      begin
         int dones = 0;
         startE = 1'b1; funct3E = 3'b000; srcAE = 32'd9; srcBE = 32'd9;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (doneE) dones++;
            @(posedge clk); #1;
            startE = 1'b0;
         end
         rst_n = 1'b0;
         @(negedge clk);
         check("rst_mul_in_reset_stall", {31'd0, stallE}, 32'd0);
         @(posedge clk); #1;
         rst_n = 1'b1;
         @(negedge clk);
         check("rst_mul_stall", {31'd0, stallE}, 32'd0);
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (doneE) dones++;
         end
         check("rst_mul_no_done", 32'(dones), 32'd0);
         @(posedge clk); #1;
         run_op("after_rst_mul", 3'b000, 32'd9, 32'd9, 32'd81, 33);
      end

      // startE held through DONE yields exactly one doneE
      begin
         int  dones = 0;
         int  cyc   = 0;
         bit  seen  = 0;
         logic [31:0] r = '0;
         startE = 1'b1; funct3E = 3'b000; srcAE = 32'd6; srcBE = 32'd7;
         while (!seen && cyc < 100) begin
            @(negedge clk);
            if (doneE) begin seen = 1; dones++; r = resultE; end
            @(posedge clk); #1;
            cyc++;
         end
         startE = 1'b0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (doneE) dones++;
         end
         check("hold_start_done_count", 32'(dones), 32'd1);
         check("hold_start_result", r, 32'd42);
         check("hold_start_latency", 32'(cyc), 32'd34);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
